// File: rtl/demux2_stream.sv
// demux2_stream: registered 1-to-2 stream demultiplexer with per-channel delivery counters
module demux2_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Data_out_0,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] Data_out_1,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt_0,
  output logic [CNT_W-1:0] cnt_1
);
  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;
  logic             state0_q, state0_d, state1_q, state1_d;
  logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic             in_fire, in0, in1, out0, out1;
  // Handshake decode; ready depends only on the addressed channel so a stalled
  // channel never blocks traffic headed to the other one.
  always_comb begin
    in_ready = sel ? (state1_q == EMPTY) | out1_ready : (state0_q == EMPTY) | out0_ready;
    in_fire  = in_valid & in_ready;
    in0      = in_fire & ~sel;
    in1      = in_fire & sel;
    out0     = (state0_q == FULL) & out0_ready;
    out1     = (state1_q == FULL) & out1_ready;
  end
  // Next state per channel: a new word keeps or makes it FULL, a lone drain empties it.
  always_comb begin
    state0_d = in0 ? FULL : (out0 ? EMPTY : state0_q);
    state1_d = in1 ? FULL : (out1 ? EMPTY : state1_q);
    data0_d  = in0 ? Data_in : data0_q;
    data1_d  = in1 ? Data_in : data1_q;
    cnt0_d   = cnt0_q + CNT_W'(out0);
    cnt1_d   = cnt1_q + CNT_W'(out1);
  end
  // State registers; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state0_q <= EMPTY;
      state1_q <= EMPTY;
      data0_q  <= '0;
      data1_q  <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state0_q <= state0_d;
      state1_q <= state1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end
  assign Data_out_0 = data0_q;
  assign Data_out_1 = data1_q;
  assign out0_valid = (state0_q == FULL);
  assign out1_valid = (state1_q == FULL);
  assign cnt_0      = cnt0_q;
  assign cnt_1      = cnt1_q;
endmodule

// File: tb/tb_demux2_stream.sv
// tb_demux2_stream: directed checks of routing, stalls, streaming, counter wrap and async reset
module tb_demux2_stream;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] Data_in = '0;
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] Data_out_0, Data_out_1;
  logic       out0_valid, out1_valid;
  logic       out0_ready = 1'b0;
  logic       out1_ready = 1'b0;
  logic [7:0] cnt_0, cnt_1;
  int         tests = 0;
  int         failed = 0;

  demux2_stream #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .Data_in(Data_in), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .Data_out_0(Data_out_0), .out0_valid(out0_valid),
    .out0_ready(out0_ready), .Data_out_1(Data_out_1), .out1_valid(out1_valid),
    .out1_ready(out1_ready), .cnt_0(cnt_0), .cnt_1(cnt_1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    @(posedge clk);
    #1;
    in_valid = v;
    sel = s;
    Data_in = d;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_v0", out0_valid, 0);
    chk("rst_v1", out1_valid, 0);
    chk("rst_c0", cnt_0, 0);
    // T2 route
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive(1, 0, 8'h3C);
    @(negedge clk);
    chk("t2_rdy", in_ready, 1);
    drive(1, 1, 8'hC3);
    @(negedge clk);
    chk("t2_v0", out0_valid, 1);
    chk("t2_d0", Data_out_0, 8'h3C);
    chk("t2_v1_early", out1_valid, 0);
    drive(0, 0, 8'hFF);
    @(negedge clk);
    chk("t2_v1", out1_valid, 1);
    chk("t2_d1", Data_out_1, 8'hC3);
    chk("t2_v0_drained", out0_valid, 0);
    chk("t2_c0", cnt_0, 1);
    drive(0, 1, 8'hEE);
    @(negedge clk);
    chk("t2_c1", cnt_1, 1);
    chk("t2_v1_drained", out1_valid, 0);
    chk("t2_idle_v0", out0_valid, 0);
    // T3 stall
    out1_ready = 1'b0;
    drive(1, 1, 8'h11);
    @(negedge clk);
    chk("t3_rdy1", in_ready, 1);
    drive(1, 1, 8'h22);
    @(negedge clk);
    chk("t3_rdy2", in_ready, 0);
    chk("t3_d1", Data_out_1, 8'h11);
    drive(1, 1, 8'h22);
    @(negedge clk);
    chk("t3_hold_d1", Data_out_1, 8'h11);
    chk("t3_hold_c1", cnt_1, 1);
    #1 sel = 1'b0;
    Data_in = 8'h33;
    #1 chk("t3_rdy_ch0", in_ready, 1);
    drive(1, 1, 8'h22);
    out1_ready = 1'b1;
    @(negedge clk);
    chk("t3_d0", Data_out_0, 8'h33);
    chk("t3_d1_first", Data_out_1, 8'h11);
    chk("t3_rdy_b2b", in_ready, 1);
    drive(0, 0, 8'h00);
    @(negedge clk);
    chk("t3_d1_second", Data_out_1, 8'h22);
    chk("t3_v1", out1_valid, 1);
    chk("t3_c1", cnt_1, 2);
    chk("t3_c0", cnt_0, 2);
    drive(0, 0, 8'h00);
    @(negedge clk);
    chk("t3_v1_drained", out1_valid, 0);
    chk("t3_c1_final", cnt_1, 3);
    // T4 back-to-back on channel 0
    for (int i = 1; i <= 16; i++) begin
      drive(1, 0, 8'(i));
      @(negedge clk);
      chk("t4_rdy", in_ready, 1);
      if (i > 1) begin
        chk("t4_d0", Data_out_0, i - 1);
        chk("t4_v0", out0_valid, 1);
      end
    end
    drive(0, 0, 8'h00);
    @(negedge clk);
    chk("t4_last", Data_out_0, 8'h10);
    drive(0, 0, 8'h00);
    @(negedge clk);
    chk("t4_c0", cnt_0, 18);
    // T5 counter wrap on channel 1
    for (int i = 0; i < 256; i++) drive(1, 1, 8'(i));
    drive(0, 0, 8'h00);
    drive(0, 0, 8'h00);
    @(negedge clk);
    chk("t5_c1_wrap", cnt_1, 3);
    chk("t5_c0_same", cnt_0, 18);
    chk("t5_v1", out1_valid, 0);
    // T6 simultaneous drain with reload of channel 0
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    drive(1, 0, 8'h55);
    drive(1, 1, 8'h66);
    drive(1, 0, 8'h77);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    @(negedge clk);
    chk("t6_v0", out0_valid, 1);
    chk("t6_v1", out1_valid, 1);
    chk("t6_rdy", in_ready, 1);
    chk("t6_c0_pre", cnt_0, 18);
    drive(0, 1, 8'h99);
    @(negedge clk);
    chk("t6_d0", Data_out_0, 8'h77);
    chk("t6_v0_reload", out0_valid, 1);
    chk("t6_v1_drained", out1_valid, 0);
    chk("t6_c0", cnt_0, 19);
    chk("t6_c1", cnt_1, 4);
    drive(0, 1, 8'h99);
    @(negedge clk);
    chk("t6_c0_final", cnt_0, 20);
    // T1 asynchronous reset while channel 0 holds a word
    out0_ready = 1'b0;
    drive(1, 0, 8'hA5);
    drive(0, 0, 8'h00);
    @(negedge clk);
    chk("t1_pre_v0", out0_valid, 1);
    chk("t1_pre_d0", Data_out_0, 8'hA5);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_v0", out0_valid, 0);
    chk("t1_d0", Data_out_0, 0);
    chk("t1_c0", cnt_0, 0);
    chk("t1_c1", cnt_1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_after_v0", out0_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
